pll_lock_supervisor: RTL and testbench



---
 rtl/pll_lock_supervisor.sv | 135 +++++++++++++
 tb/tb_pll_lock_supervisor.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_lock_supervisor.sv
// Sequences the VGA PLL reset, qualifies lock over a programmable window and
// releases the pixel-domain root reset; re-resets the PLL on loss or timeout.
module pll_lock_supervisor #(
  parameter int RST_PULSE_CYCLES    = 16,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 480000,
  parameter int CNT_W               = 20
) (
  input  logic       clkin,
  input  logic       reset_n,
  input  logic       pll_locked,
  input  logic       force_relock,
  output logic       pll_reset,
  output logic       domain_reset_n,
  output logic       ready,
  output logic       lock_lost,
  output logic [7:0] retry_count
);

  // state     | meaning
  // RESET_PLL | PLL held in reset for RST_PULSE_CYCLES
  // WAIT_LOCK | PLL running, waiting for lock or timeout
  // STABLE    | lock seen, must hold for LOCK_STABLE_CYCLES
  // RUN       | pixel domain released, lock monitored

  if (((64'd1 << CNT_W) <= 64'(RST_PULSE_CYCLES)) ||
      ((64'd1 << CNT_W) <= 64'(LOCK_STABLE_CYCLES)) ||
      ((64'd1 << CNT_W) <= 64'(LOCK_TIMEOUT_CYCLES))) begin : g_cnt_w_check
    $error("pll_lock_supervisor: CNT_W too narrow for the configured counts");
  end

  localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

  typedef enum logic [1:0] {RESET_PLL, WAIT_LOCK, STABLE, RUN} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             sync_q1;
  logic             locked_s;
  logic [7:0]       retry_inc;

  assign retry_inc = (retry_count == 8'hFF) ? retry_count : retry_count + 8'd1;

  always_ff @(posedge clkin or negedge reset_n) begin
    if (!reset_n) begin
      state          <= RESET_PLL;
      cnt            <= '0;
      sync_q1        <= 1'b0;
      locked_s       <= 1'b0;
      pll_reset      <= 1'b1;
      domain_reset_n <= 1'b0;
      ready          <= 1'b0;
      lock_lost      <= 1'b0;
      retry_count    <= 8'd0;
    end else begin
      sync_q1   <= pll_locked;
      locked_s  <= sync_q1;
      lock_lost <= 1'b0;
      case (state)
        RESET_PLL: begin
          // force_relock deliberately ignored: the pulse in progress completes
          if (cnt == RST_LAST) begin
            state     <= WAIT_LOCK;
            cnt       <= '0;
            pll_reset <= 1'b0;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        WAIT_LOCK: begin
          if (force_relock) begin
            state     <= RESET_PLL;
            cnt       <= '0;
            pll_reset <= 1'b1;
          end else if (locked_s) begin
            state <= STABLE;
            cnt   <= '0;
          end else if (cnt == TIMEOUT_LAST) begin
            state       <= RESET_PLL;
            cnt         <= '0;
            pll_reset   <= 1'b1;
            retry_count <= retry_inc;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        STABLE: begin
          if (force_relock) begin
            state     <= RESET_PLL;
            cnt       <= '0;
            pll_reset <= 1'b1;
          end else if (!locked_s) begin
            state <= WAIT_LOCK;
            cnt   <= '0;
          end else if (cnt == STABLE_LAST) begin
            state          <= RUN;
            cnt            <= '0;
            domain_reset_n <= 1'b1;
            ready          <= 1'b1;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        RUN: begin
          if (force_relock) begin
            state          <= RESET_PLL;
            cnt            <= '0;
            pll_reset      <= 1'b1;
            domain_reset_n <= 1'b0;
            ready          <= 1'b0;
          end else if (!locked_s) begin
            state          <= RESET_PLL;
            cnt            <= '0;
            pll_reset      <= 1'b1;
            domain_reset_n <= 1'b0;
            ready          <= 1'b0;
            lock_lost      <= 1'b1;
            retry_count    <= retry_inc;
          end
        end
        default: begin
          state          <= RESET_PLL;
          cnt            <= '0;
          pll_reset      <= 1'b1;
          domain_reset_n <= 1'b0;
          ready          <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Bench for pll_lock_supervisor: power-up table, hand-written corner sequences
// and a randomized run, all checked against an elapsed-time reference model.
module tb_pll_lock_supervisor;

  localparam int RSTP = 4;
  localparam int LSTB = 8;
  localparam int TOUT = 32;

  logic       clkin;
  logic       reset_n;
  logic       pll_locked;
  logic       force_relock;
  logic       pll_reset;
  logic       domain_reset_n;
  logic       ready;
  logic       lock_lost;
  logic [7:0] retry_count;

  int vectors;
  int miscompares;
  int edge_n;

  pll_lock_supervisor #(
    .RST_PULSE_CYCLES(RSTP),
    .LOCK_STABLE_CYCLES(LSTB),
    .LOCK_TIMEOUT_CYCLES(TOUT),
    .CNT_W(20)
  ) dut (
    .clkin(clkin),
    .reset_n(reset_n),
    .pll_locked(pll_locked),
    .force_relock(force_relock),
    .pll_reset(pll_reset),
    .domain_reset_n(domain_reset_n),
    .ready(ready),
    .lock_lost(lock_lost),
    .retry_count(retry_count)
  );

  initial clkin = 1'b0;
  always #5 clkin = ~clkin;

  // Reference model: phase plus the edge number it was entered on; durations
  // are elapsed-edge arithmetic. locked_s is the input seen two edges ago.
  localparam int P_RST = 0, P_WAIT = 1, P_STB = 2, P_RUN = 3;
  int m_phase;
  int m_entered;
  int m_retry;
  bit m_ll;
  bit m_hist[2];

  function automatic void model_reset();
    m_phase   = P_RST;
    m_entered = 0;
    m_retry   = 0;
    m_ll      = 1'b0;
    m_hist[0] = 1'b0;
    m_hist[1] = 1'b0;
    edge_n    = 0;
  endfunction

  function automatic void go(input int ph);
    m_phase   = ph;
    m_entered = edge_n;
  endfunction

  function automatic void model_step(input bit pl, input bit fr);
    bit ls;
    int el;
    edge_n++;
    ls        = m_hist[1];
    m_hist[1] = m_hist[0];
    m_hist[0] = pl;
    m_ll      = 1'b0;
    el        = edge_n - m_entered;
    if (m_phase == P_RST) begin
      if (el == RSTP) go(P_WAIT);
    end else if (fr) begin
      go(P_RST);
    end else if (m_phase == P_WAIT) begin
      if (ls) go(P_STB);
      else if (el == TOUT) begin
        go(P_RST);
        if (m_retry < 255) m_retry++;
      end
    end else if (m_phase == P_STB) begin
      if (!ls) go(P_WAIT);
      else if (el == LSTB) go(P_RUN);
    end else begin
      if (!ls) begin
        go(P_RST);
        m_ll = 1'b1;
        if (m_retry < 255) m_retry++;
      end
    end
  endfunction

  task automatic chk1(input string nm, input logic act, input logic exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s edge %0d: got %b expected %b", nm, edge_n, act, exp);
    end
  endtask

  task automatic chk8(input string nm, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s edge %0d: got %0d expected %0d", nm, edge_n, act, exp);
    end
  endtask

  task automatic tick(input bit pl, input bit fr);
    pll_locked   = pl;
    force_relock = fr;
    @(posedge clkin);
    model_step(pl, fr);
    #1;
    chk1("model_pll_reset", pll_reset, m_phase == P_RST);
    chk1("model_domain_reset_n", domain_reset_n, m_phase == P_RUN);
    chk1("model_ready", ready, m_phase == P_RUN);
    chk1("model_lock_lost", lock_lost, m_ll);
    chk8("model_retry_count", retry_count, 8'(m_retry));
  endtask

  task automatic apply_reset();
    pll_locked   = 1'b0;
    force_relock = 1'b0;
    reset_n      = 1'b0;
    @(negedge clkin);
    @(negedge clkin);
    reset_n = 1'b1;
    model_reset();
  endtask

  typedef struct {
    bit         pl;
    bit         fr;
    bit         e_pr;
    bit         e_drn;
    logic [7:0] e_rc;
  } vec_t;

  vec_t tbl[22];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit pl_cur;
    int run_left;
    vectors     = 0;
    miscompares = 0;
    edge_n      = 0;
    reset_n     = 1'b0;
    pll_locked  = 1'b0;
    force_relock = 1'b0;

    for (int i = 0; i < 22; i++) begin
      tbl[i].pl    = (i + 1 >= 10);
      tbl[i].fr    = 1'b0;
      tbl[i].e_pr  = (i + 1 < RSTP);
      tbl[i].e_drn = (i + 1 >= 20);
      tbl[i].e_rc  = 8'd0;
    end

    // Reset values while reset_n is held low
    @(negedge clkin);
    @(negedge clkin);
    chk1("rst_pll_reset", pll_reset, 1'b1);
    chk1("rst_domain_reset_n", domain_reset_n, 1'b0);
    chk1("rst_ready", ready, 1'b0);
    chk1("rst_lock_lost", lock_lost, 1'b0);
    chk8("rst_retry_count", retry_count, 8'd0);
    reset_n = 1'b1;
    model_reset();

    // Power-up with lock from edge 10: release after edge 20
    for (int i = 0; i < 22; i++) begin
      tick(tbl[i].pl, tbl[i].fr);
      chk1("tbl_pll_reset", pll_reset, tbl[i].e_pr);
      chk1("tbl_domain_reset_n", domain_reset_n, tbl[i].e_drn);
      chk1("tbl_ready", ready, tbl[i].e_drn);
      chk8("tbl_retry_count", retry_count, tbl[i].e_rc);
    end

    // Lock loss in RUN at edge j
    tick(1'b0, 1'b0);
    chk1("loss_j_drn", domain_reset_n, 1'b1);
    tick(1'b0, 1'b0);
    chk1("loss_j1_drn", domain_reset_n, 1'b1);
    tick(1'b0, 1'b0);
    chk1("loss_j2_drn", domain_reset_n, 1'b0);
    chk1("loss_j2_pll_reset", pll_reset, 1'b1);
    chk1("loss_j2_lock_lost", lock_lost, 1'b1);
    chk8("loss_j2_retry", retry_count, 8'd1);
    tick(1'b0, 1'b0);
    chk1("loss_j3_lock_lost", lock_lost, 1'b0);
    repeat (3) tick(1'b0, 1'b0);
    chk1("loss_j6_pll_reset", pll_reset, 1'b0);
    repeat (10) tick(1'b1, 1'b0);
    chk1("relock_k9_drn", domain_reset_n, 1'b0);
    tick(1'b1, 1'b0);
    chk1("relock_k10_drn", domain_reset_n, 1'b1);
    chk1("relock_k10_ready", ready, 1'b1);

    // force_relock coincident with locked_s falling in RUN
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b1);
    chk1("force_run_pll_reset", pll_reset, 1'b1);
    chk1("force_run_lock_lost", lock_lost, 1'b0);
    chk1("force_run_drn", domain_reset_n, 1'b0);
    chk8("force_run_retry", retry_count, 8'd1);
    // force_relock during the pulse does not stretch it
    repeat (3) tick(1'b0, 1'b1);
    chk1("force_rst_still_high", pll_reset, 1'b1);
    chk1("force_rst_lock_lost", lock_lost, 1'b0);
    tick(1'b0, 1'b0);
    chk1("force_rst_len4", pll_reset, 1'b0);

    // One-cycle glitch while STABLE cnt=5: full requalification
    repeat (6) tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    repeat (4) tick(1'b1, 1'b0);
    chk1("glitch_no_early_drn", domain_reset_n, 1'b0);
    repeat (6) tick(1'b1, 1'b0);
    chk1("glitch_k16_drn", domain_reset_n, 1'b0);
    tick(1'b1, 1'b0);
    chk1("glitch_k17_drn", domain_reset_n, 1'b1);
    chk8("glitch_retry", retry_count, 8'd1);

    // Async reset mid-WAIT_LOCK between edges
    tick(1'b0, 1'b1);
    repeat (7) tick(1'b0, 1'b0);
    chk1("wait_pll_reset", pll_reset, 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    chk1("async_pll_reset", pll_reset, 1'b1);
    chk1("async_drn", domain_reset_n, 1'b0);
    chk1("async_ready", ready, 1'b0);
    chk1("async_lock_lost", lock_lost, 1'b0);
    chk8("async_retry", retry_count, 8'd0);
    @(negedge clkin);
    @(negedge clkin);
    reset_n = 1'b1;
    model_reset();

    // Lock never arrives: re-pulse every 36 edges, retry saturates at 255
    for (int p = 1; p <= 3; p++) begin
      repeat (RSTP + TOUT - 1) tick(1'b0, 1'b0);
      chk1("tout_before_pll_reset", pll_reset, 1'b0);
      tick(1'b0, 1'b0);
      chk1("tout_pll_reset", pll_reset, 1'b1);
      chk8("tout_retry", retry_count, 8'(p));
    end
    repeat (257 * (RSTP + TOUT)) tick(1'b0, 1'b0);
    chk1("sat_pll_reset", pll_reset, 1'b1);
    chk8("sat_retry", retry_count, 8'd255);

    // Randomized lock behaviour and relock requests
    apply_reset();
    run_left = 0;
    pl_cur   = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (run_left == 0) begin
        pl_cur   = ($urandom_range(0, 3) != 0);
        run_left = $urandom_range(1, 40);
      end
      run_left--;
      tick(pl_cur, $urandom_range(0, 49) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
